// File: rtl/prime_scan.sv
// ---------------------------------------------------------------------------
// prime_scan
//
// Sequential candidate generator feeding the 5-bit prime detector path.
// A run sweeps the inclusive range [lo, hi], evaluating one candidate per
// clock. Every prime found is pushed into a small FIFO. The FIFO is drained
// over a valid/ready stream.
//
// Parameters
//   DEPTH        FIFO entries (power of two, >= 2), default 4
//
// Ports
//   clk          in   1  single clock, rising edge
//   rst_n        in   1  synchronous active-low reset
//   start        in   1  begin a run (only looked at in IDLE)
//   lo           in   5  first candidate, captured with start
//   hi           in   5  last candidate (inclusive), captured with start
//   out_valid    out  1  FIFO holds at least one prime
//   out_ready    in   1  consumer takes out_data this cycle
//   out_data     out  5  oldest buffered prime, 0 while out_valid=0
//   busy         out  1  high in SCAN and DRAIN
//   done         out  1  one-cycle pulse at the end of a run
//   prime_count  out  4  primes pushed in the current or last run
//
// Configuration macro
//   PRIME_SCAN_COUNT_EN  when defined, prime_count is a live counter;
//                        otherwise the counter is not built and
//                        prime_count reads 4'd0.
// ---------------------------------------------------------------------------
module prime_scan #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [4:0] lo,
    input  logic [4:0] hi,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_data,
    output logic       busy,
    output logic       done,
    output logic [3:0] prime_count
);

    // Pointer width and occupancy width (occupancy must be able to hold DEPTH).
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_EMPTY = CW'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Primality of a 5-bit value: the fixed set {2,3,5,7,11,13,17,19,23,29,31}.
    // -----------------------------------------------------------------------
    function automatic logic is_prime5(input logic [4:0] v);
        logic r;
        case (v)
            5'd2, 5'd3, 5'd5, 5'd7, 5'd11, 5'd13,
            5'd17, 5'd19, 5'd23, 5'd29, 5'd31: r = 1'b1;
            default:                           r = 1'b0;
        endcase
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t         state_q, state_d;
    logic [4:0]     cand_q,  cand_d;
    logic [4:0]     hi_q,    hi_d;

    logic [4:0]     mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q,  count_d;

    logic           cand_prime_s;
    logic           full_s;
    logic           empty_s;
    logic           push_s;
    logic           pop_s;

    // FIFO status is judged on registered occupancy only, so a pop in the
    // same cycle never frees a slot for a push in that cycle.
    assign full_s       = (count_q == CNT_FULL);
    assign empty_s      = (count_q == CNT_EMPTY);
    assign pop_s        = (!empty_s) && out_ready;
    assign cand_prime_s = is_prime5(cand_q);

    // Next-state logic for the scan FSM, candidate and captured bound.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        hi_d    = hi_q;
        push_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cand_d = lo;
                    hi_d   = hi;
                    // An inverted range has nothing to scan; finish via DRAIN.
                    if (lo <= hi) begin
                        state_d = ST_SCAN;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (cand_prime_s && full_s) begin
                    // Backpressure: hold the prime candidate until a slot opens.
                    state_d = ST_SCAN;
                end else begin
                    push_s = cand_prime_s;
                    // Equality test so hi=31 terminates without wrapping cand.
                    if (cand_q == hi_q) begin
                        state_d = ST_DRAIN;
                    end else begin
                        cand_d  = cand_q + 5'd1;
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_DRAIN: begin
                if (empty_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, candidate and bound registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cand_q  <= 5'd0;
            hi_q    <= 5'd0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            hi_q    <= hi_d;
        end
    end

    // FIFO pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; cleared on reset so stale primes never leak out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 5'd0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= cand_q;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    // Outputs are decoded straight from registered state.
    assign out_valid = !empty_s;
    assign out_data  = empty_s ? 5'd0 : mem_q[rd_ptr_q];
    assign busy      = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);

`ifdef PRIME_SCAN_COUNT_EN
    logic [3:0] pcount_q, pcount_d;
    logic       start_acc_s;

    assign start_acc_s = (state_q == ST_IDLE) && start;

    // Run counter: cleared on an accepted start, bumped on each push,
    // otherwise held so the last run's total stays visible.
    always_comb begin
        pcount_d = pcount_q;
        if (start_acc_s) begin
            pcount_d = 4'd0;
        end else if (push_s) begin
            pcount_d = pcount_q + 4'd1;
        end else begin
            pcount_d = pcount_q;
        end
    end

    // Run counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcount_q <= 4'd0;
        end else begin
            pcount_q <= pcount_d;
        end
    end

    assign prime_count = pcount_q;
`else
    assign prime_count = 4'd0;
`endif

endmodule

// File: tb/tb_prime_scan.sv
module tb_prime_scan;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [4:0] lo;
    logic [4:0] hi;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_data;
    logic       busy;
    logic       done;
    logic [3:0] prime_count;

    int         checks   = 0;
    int         failures = 0;
    int         done_cnt = 0;
    int         pop_cnt  = 0;
    bit         mon_en   = 1'b0;
    logic [4:0] sbq [$];
    logic [4:0] exp_v;

    always #5 clk = ~clk;

    prime_scan #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .lo          (lo),
        .hi          (hi),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done),
        .prime_count (prime_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Independent primality by trial division.
    function automatic bit tb_is_prime(input int v);
        if (v < 2) return 1'b0;
        for (int d = 2; d * d <= v; d++) begin
            if (v % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int exp_pc(input int n);
`ifdef PRIME_SCAN_COUNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic load_expect(input int l, input int h, output int n);
        n = 0;
        for (int v = l; v <= h; v++) begin
            if (tb_is_prime(v)) begin
                sbq.push_back(5'(v));
                n++;
            end
        end
    endtask

    task automatic kick(input int l, input int h);
        @(posedge clk); #2;
        start = 1'b1;
        lo    = 5'(l);
        hi    = 5'(h);
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int bound);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk); #1;
            if (done_cnt != base) seen = 1'b1;
        end
        check_eq("done_seen", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        check_eq("done_once", 32'(done_cnt - base), 32'd1);
        check_eq("busy_after", 32'(busy), 32'd0);
        check_eq("sb_empty", 32'(sbq.size()), 32'd0);
    endtask

    // Output monitor: pops the scoreboard on each accepted beat.
    always @(negedge clk) begin
        if (mon_en) begin
            if (done) begin
                done_cnt++;
                check_eq("busy_with_done", 32'(busy), 32'd0);
            end
            if (out_valid) begin
                if (out_ready) begin
                    if (sbq.size() == 0) begin
                        check_eq("sb_underflow", 32'(sbq.size()), 32'd1);
                    end else begin
                        exp_v = sbq.pop_front();
                        check_eq("out_data", 32'(out_data), 32'(exp_v));
                        pop_cnt++;
                    end
                end
            end else begin
                check_eq("idle_data_zero", 32'(out_data), 32'd0);
            end
        end
    end

    initial begin
        int n;
        int base;
        int pbase;
        bit hit;

        rst_n = 1'b0; start = 1'b0; lo = 5'd0; hi = 5'd0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_data", 32'(out_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_count", 32'(prime_count), 32'd0);
        @(posedge clk); #2;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Latency: lo=3 -> prime evaluated in cycle 1, visible in cycle 2.
        load_expect(3, 5, n);
        base = done_cnt;
        kick(3, 5);
        @(negedge clk); #1;
        check_eq("lat_busy_c1", 32'(busy), 32'd1);
        check_eq("lat_valid_c1", 32'(out_valid), 32'd0);
        @(negedge clk); #1;
        check_eq("lat_valid_c2", 32'(out_valid), 32'd1);
        wait_done(base, 100);
        check_eq("lat_count", 32'(prime_count), 32'(exp_pc(n)));

        // Full sweep.
        load_expect(0, 31, n);
        base = done_cnt;
        kick(0, 31);
        wait_done(base, 200);
        check_eq("sweep_count", 32'(prime_count), 32'(exp_pc(n)));

        // Prime-free range.
        load_expect(14, 16, n);
        base  = done_cnt;
        pbase = pop_cnt;
        kick(14, 16);
        wait_done(base, 100);
        check_eq("free_pops", 32'(pop_cnt - pbase), 32'd0);
        check_eq("free_count", 32'(prime_count), 32'(exp_pc(n)));

        // Inverted range: cycle-exact busy/done.
        base = done_cnt;
        @(posedge clk); #2;
        start = 1'b1; lo = 5'd20; hi = 5'd10;
        @(negedge clk); #1;
        check_eq("inv_busy_c0", 32'(busy), 32'd0);
        @(posedge clk); #2;
        start = 1'b0;
        @(negedge clk); #1;
        check_eq("inv_busy_c1", 32'(busy), 32'd1);
        check_eq("inv_done_c1", 32'(done), 32'd0);
        @(negedge clk); #1;
        check_eq("inv_busy_c2", 32'(busy), 32'd0);
        check_eq("inv_done_c2", 32'(done), 32'd1);
        @(negedge clk); #1;
        check_eq("inv_done_c3", 32'(done), 32'd0);
        check_eq("inv_done_once", 32'(done_cnt - base), 32'd1);
        check_eq("inv_count", 32'(prime_count), 32'd0);

        // Backpressure with a full FIFO.
        out_ready = 1'b0;
        load_expect(0, 31, n);
        base = done_cnt;
        kick(0, 31);
        repeat (30) @(negedge clk);
        #1;
        check_eq("bp_valid", 32'(out_valid), 32'd1);
        check_eq("bp_head", 32'(out_data), 32'd2);
        check_eq("bp_busy", 32'(busy), 32'd1);
        check_eq("bp_count", 32'(prime_count), 32'(exp_pc(4)));
        check_eq("bp_no_done", 32'(done_cnt - base), 32'd0);
        @(posedge clk); #2;
        out_ready = 1'b1;
        wait_done(base, 200);
        check_eq("bp_final_count", 32'(prime_count), 32'(exp_pc(n)));

        // Mid-scan reset after the third output.
        load_expect(0, 31, n);
        pbase = pop_cnt;
        kick(0, 31);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk); #1;
            if (pop_cnt - pbase >= 3) hit = 1'b1;
        end
        check_eq("mr_third_out", 32'(hit), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        sbq.delete();
        @(negedge clk); #1;
        check_eq("mr_valid", 32'(out_valid), 32'd0);
        check_eq("mr_data", 32'(out_data), 32'd0);
        check_eq("mr_busy", 32'(busy), 32'd0);
        check_eq("mr_done", 32'(done), 32'd0);
        check_eq("mr_count", 32'(prime_count), 32'd0);
        load_expect(29, 31, n);
        base = done_cnt;
        kick(29, 31);
        wait_done(base, 100);
        check_eq("mr_rerun_count", 32'(prime_count), 32'(exp_pc(n)));

        // Start while busy is ignored.
        load_expect(0, 31, n);
        base = done_cnt;
        kick(0, 31);
        repeat (4) @(posedge clk);
        #2;
        start = 1'b1; lo = 5'd5; hi = 5'd6;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(base, 200);
        check_eq("sb_busy_count", 32'(prime_count), 32'(exp_pc(n)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
